cmd_arb: RTL and testbench

Round-robin arbiter sharing the single register-write command bus (address/data/valid from a COBS decode + command parse chain) between `N` command sources, e.g. a host UART link and an on-board debug link. Each source presents fully parsed commands. The arbiter grants one source at a time with bounded bursts and drives one registered output command toward the register bank. It adds a source ID so the downstream bank can log or filter by origin.

---
 rtl/cmd_pkg.sv | 17 +
 rtl/cmd_arb_rr_pick.sv | 32 +++
 rtl/cmd_arb.sv | 131 +++++++++++++
 tb/tb_cmd_arb.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_pkg.sv
// Shared command-path definitions: arbiter state type, source-index width helper
// and the address/data widths also used by the command parse stage.
package cmd_pkg;

  localparam int CMD_AW = 8;
  localparam int CMD_DW = 24;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  function automatic int src_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cmd_arb_rr_pick.sv
// Round-robin request picker: returns the first set request at or after
// 'start', wrapping modulo N. Purely combinational.
module rr_pick
  import cmd_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]        req,
  input  logic [src_w(N)-1:0] start,
  output logic                any,
  output logic [src_w(N)-1:0] idx
);

  localparam int SW = src_w(N);

  logic [SW-1:0] k;

  // Offsets are walked downward so the request nearest to start is written last.
  always_comb begin
    any = 1'b0;
    idx = '0;
    k   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      k = SW'((int'(start) + i) % N);
      if (req[k]) begin
        any = 1'b1;
        idx = k;
      end
    end
  end

endmodule

// File: rtl/cmd_arb.sv
// Round-robin arbiter merging N parsed command sources onto one registered
// register-write command bus, with bounded bursts and a source-ID tag.
module cmd_arb
  import cmd_pkg::*;
#(
  parameter int N         = 2,
  parameter int AW        = CMD_AW,
  parameter int DW        = CMD_DW,
  parameter int MAX_BURST = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N*AW-1:0]     i_addr,
  input  logic [N*DW-1:0]     i_data,
  input  logic [N-1:0]        i_valid,
  output logic [N-1:0]        o_ready,
  output logic [AW-1:0]       o_addr,
  output logic [DW-1:0]       o_data,
  output logic [src_w(N)-1:0] o_src,
  output logic                o_valid,
  input  logic                i_ready
);

  localparam int SW = src_w(N);
  localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);
  localparam logic [SW-1:0] SRC_LAST = SW'(N - 1);

  arb_state_t    state_q, state_d;
  logic [SW-1:0] gnt_q, gnt_d;
  logic [SW-1:0] rr_q, rr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] pick_idx;
  logic          pick_any;
  logic          slot_free;
  logic          xfer;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;

  logic [AW-1:0] addr_p1;
  logic [DW-1:0] data_p1;
  logic [SW-1:0] src_p1;
  logic          vld_p1;

  rr_pick #(.N(N)) u_pick (
    .req   (i_valid),
    .start (rr_q),
    .any   (pick_any),
    .idx   (pick_idx)
  );

  assign slot_free = !vld_p1 || i_ready;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int k = 0; k < N; k++) begin
      if (gnt_q == SW'(k)) begin
        sel_addr = i_addr[k*AW +: AW];
        sel_data = i_data[k*DW +: DW];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    o_ready = '0;
    xfer    = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          gnt_d   = pick_idx;
          cnt_d   = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        o_ready[gnt_q] = slot_free;
        xfer           = slot_free && i_valid[gnt_q];
        // A full burst or an idle granted source hands the turn to the next index.
        if ((xfer && (cnt_q == CNT_LAST)) || (slot_free && !i_valid[gnt_q])) begin
          state_d = IDLE;
          rr_d    = (gnt_q == SRC_LAST) ? '0 : gnt_q + 1'b1;
        end else if (xfer) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Output slot: single register stage toward the register bank
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_p1 <= '0;
      data_p1 <= '0;
      src_p1  <= '0;
      vld_p1  <= 1'b0;
    end else if (xfer) begin
      addr_p1 <= sel_addr;
      data_p1 <= sel_data;
      src_p1  <= gnt_q;
      vld_p1  <= 1'b1;
    end else if (i_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign o_addr  = addr_p1;
  assign o_data  = data_p1;
  assign o_src   = src_p1;
  assign o_valid = vld_p1;

endmodule

// File: tb/tb_cmd_arb.sv
// Bench for cmd_arb: two configurations (N=2/MAX_BURST=4 and N=3/MAX_BURST=1)
// driven from per-source command lists and checked against a transaction model.
module tb_cmd_arb;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sel = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  v_valid = '0;
  logic [7:0]  v_addr [3];
  logic [23:0] v_data [3];
  logic        v_iready = 1'b1;

  logic [15:0] a_iaddr;
  logic [47:0] a_idata;
  logic [1:0]  a_ivalid, a_ordy;
  logic [7:0]  a_oaddr;
  logic [23:0] a_odata;
  logic [0:0]  a_osrc;
  logic        a_ovalid, a_iready;

  logic [23:0] b_iaddr;
  logic [71:0] b_idata;
  logic [2:0]  b_ivalid, b_ordy;
  logic [7:0]  b_oaddr;
  logic [23:0] b_odata;
  logic [1:0]  b_osrc;
  logic        b_ovalid, b_iready;

  assign a_iaddr  = {v_addr[1], v_addr[0]};
  assign a_idata  = {v_data[1], v_data[0]};
  assign a_ivalid = sel ? 2'b00 : v_valid[1:0];
  assign a_iready = sel ? 1'b1 : v_iready;
  assign b_iaddr  = {v_addr[2], v_addr[1], v_addr[0]};
  assign b_idata  = {v_data[2], v_data[1], v_data[0]};
  assign b_ivalid = sel ? v_valid : 3'b000;
  assign b_iready = sel ? v_iready : 1'b1;

  cmd_arb #(.N(2), .AW(8), .DW(24), .MAX_BURST(4)) dut_a (
    .clk(clk), .rst(rst), .i_addr(a_iaddr), .i_data(a_idata), .i_valid(a_ivalid),
    .o_ready(a_ordy), .o_addr(a_oaddr), .o_data(a_odata), .o_src(a_osrc),
    .o_valid(a_ovalid), .i_ready(a_iready)
  );

  cmd_arb #(.N(3), .AW(8), .DW(24), .MAX_BURST(1)) dut_b (
    .clk(clk), .rst(rst), .i_addr(b_iaddr), .i_data(b_idata), .i_valid(b_ivalid),
    .o_ready(b_ordy), .o_addr(b_oaddr), .o_data(b_odata), .o_src(b_osrc),
    .o_valid(b_ovalid), .i_ready(b_iready)
  );

  logic [2:0]  ob_ready;
  logic [7:0]  ob_addr;
  logic [23:0] ob_data;
  logic [1:0]  ob_src;
  logic        ob_valid;
  assign ob_ready = sel ? b_ordy   : {1'b0, a_ordy};
  assign ob_addr  = sel ? b_oaddr  : a_oaddr;
  assign ob_data  = sel ? b_odata  : a_odata;
  assign ob_src   = sel ? b_osrc   : {1'b0, a_osrc};
  assign ob_valid = sel ? b_ovalid : a_ovalid;

  logic [31:0] src_cmds [3][64];
  int          src_len [3];
  int          in_head [3];
  int          out_head [3];
  bit          src_en [3];
  bit          acc [3];
  int          gap_pct = 0;
  bit          rnd_ready = 1'b0;
  int          nsrc = 2;
  int          cyc = 0;
  int          src_log [$];
  int          cyc_log [$];
  int          exp_q [$];
  bit          hold_prev = 1'b0;
  logic [34:0] snap;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int kk = 0; kk < 3; kk++) begin
      if (acc[kk]) begin
        in_head[kk]++;
        v_valid[kk] = 1'b0;
        acc[kk] = 1'b0;
      end
      if (!src_en[kk] || in_head[kk] >= src_len[kk]) v_valid[kk] = 1'b0;
      else if (!v_valid[kk] && int'($urandom_range(99)) >= gap_pct) v_valid[kk] = 1'b1;
      if (in_head[kk] < 64) begin
        v_addr[kk] = src_cmds[kk][in_head[kk]][31:24];
        v_data[kk] = src_cmds[kk][in_head[kk]][23:0];
      end
    end
    if (rnd_ready) v_iready = (int'($urandom_range(99)) < 70);
  endtask

  // Samples at the falling edge, then applies new stimulus just after the rising edge.
  task automatic cycle();
    logic [34:0] now;
    @(negedge clk);
    now = {ob_valid, ob_src, ob_addr, ob_data};
    chk("ready_onehot", 64'($onehot0(ob_ready)), 64'd1);
    if (ob_valid && !v_iready) chk("bp_ready_zero", ob_ready, 0);
    if (hold_prev) chk("bp_stable", now, snap);
    hold_prev = ob_valid && !v_iready;
    snap = now;
    for (int kk = 0; kk < 3; kk++) acc[kk] = v_valid[kk] && ob_ready[kk];
    if (ob_valid && v_iready) begin
      int k;
      bit ok;
      k  = int'(ob_src);
      ok = (k < nsrc) && (out_head[k] < src_len[k]);
      chk("out_in_range", ok, 1);
      if (ok) begin
        chk("out_cmd", {ob_addr, ob_data}, src_cmds[k][out_head[k]]);
        out_head[k]++;
      end
      src_log.push_back(k);
      cyc_log.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
    drive();
  endtask

  task automatic reset_model();
    for (int kk = 0; kk < 3; kk++) begin
      src_len[kk] = 0;
      in_head[kk] = 0;
      out_head[kk] = 0;
      src_en[kk] = 1'b0;
      acc[kk] = 1'b0;
      v_valid[kk] = 1'b0;
    end
    src_log.delete();
    cyc_log.delete();
    exp_q.delete();
    hold_prev = 1'b0;
    gap_pct = 0;
    rnd_ready = 1'b0;
    v_iready = 1'b1;
  endtask

  task automatic reset_dut();
    rst = 1'b0;
    reset_model();
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic load(input int k, input int n);
    for (int i = 0; i < n; i++) src_cmds[k][i] = $urandom;
    src_len[k] = n;
  endtask

  function automatic bit drained();
    for (int kk = 0; kk < 3; kk++) if (out_head[kk] != src_len[kk]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic run_drain(input string tag, input int max_cyc);
    int n;
    n = 0;
    while (!drained() && n < max_cyc) begin
      cycle();
      n++;
    end
    chk(tag, drained(), 1);
  endtask

  // Expected source order when every source keeps requesting: bursts of up to mb, rotating.
  task automatic build_exp(input int mb);
    int rem [3];
    int rr;
    int left;
    exp_q.delete();
    rr = 0;
    left = 0;
    for (int kk = 0; kk < 3; kk++) begin
      rem[kk] = (kk < nsrc) ? src_len[kk] : 0;
      left += rem[kk];
    end
    while (left > 0) begin
      int k;
      k = rr;
      while (rem[k] == 0) k = (k + 1) % nsrc;
      for (int j = 0; j < mb && rem[k] > 0; j++) begin
        exp_q.push_back(k);
        rem[k]--;
        left--;
      end
      rr = (k + 1) % nsrc;
    end
  endtask

  task automatic check_seq(input string tag, input bit gaps, input int mb);
    int run;
    chk({tag, "_count"}, src_log.size(), exp_q.size());
    run = 0;
    for (int i = 0; i < exp_q.size() && i < src_log.size(); i++) begin
      chk({tag, "_src"}, src_log[i], exp_q[i]);
      if (gaps && i > 0) begin
        if (exp_q[i] == exp_q[i-1]) chk({tag, "_gap"}, cyc_log[i] - cyc_log[i-1], 1);
        else if (run == mb) chk({tag, "_bubble"}, cyc_log[i] - cyc_log[i-1], 2);
      end
      run = (i > 0 && exp_q[i] == exp_q[i-1]) ? run + 1 : 1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int sum;
    for (int kk = 0; kk < 3; kk++) begin
      v_addr[kk] = '0;
      v_data[kk] = '0;
    end
    reset_model();
    rst = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("rst_a_valid", a_ovalid, 0);
    chk("rst_a_addr", a_oaddr, 0);
    chk("rst_a_data", a_odata, 0);
    chk("rst_a_src", a_osrc, 0);
    chk("rst_a_ready", a_ordy, 0);
    chk("rst_b_all", {b_ovalid, b_osrc, b_oaddr, b_odata, b_ordy}, 0);
    rst = 1'b1;

    // single source, three commands
    sel = 1'b0;
    nsrc = 2;
    src_cmds[0][0] = 32'h01000011;
    src_cmds[0][1] = 32'h02000022;
    src_cmds[0][2] = 32'h03000033;
    src_len[0] = 3;
    src_en[0] = 1'b1;
    drive();
    chk("t1_idle_ready", ob_ready, 0);
    cycle();
    chk("t1_arb_latency", ob_ready, 3'b001);
    cycle();
    chk("t1_first_out", {ob_valid, ob_src, ob_addr, ob_data}, {1'b1, 2'd0, 32'h01000011});
    run_drain("t1_drain", 20);
    build_exp(4);
    check_seq("t1", 1'b1, 4);

    // contention, 10 commands each
    reset_dut();
    nsrc = 2;
    load(0, 10);
    load(1, 10);
    src_en[0] = 1'b1;
    src_en[1] = 1'b1;
    drive();
    run_drain("t2_drain", 200);
    build_exp(4);
    check_seq("t2", 1'b1, 4);

    // backpressure 1,0,0,1 during a burst
    reset_dut();
    nsrc = 2;
    load(0, 4);
    src_en[0] = 1'b1;
    drive();
    cycle();
    cycle();
    cycle();
    v_iready = 1'b0;
    cycle();
    chk("t3_hold1", {ob_valid, ob_addr, ob_data}, {1'b1, src_cmds[0][1]});
    chk("t3_ready_low1", ob_ready, 0);
    cycle();
    chk("t3_hold2", {ob_valid, ob_addr, ob_data}, {1'b1, src_cmds[0][1]});
    chk("t3_ready_low2", ob_ready, 0);
    v_iready = 1'b1;
    cycle();
    chk("t3_resume", {ob_valid, ob_addr, ob_data}, {1'b1, src_cmds[0][2]});
    run_drain("t3_drain", 20);
    build_exp(4);
    check_seq("t3", 1'b0, 4);

    // early release: source 1 sends one command while source 0 waits
    reset_dut();
    nsrc = 2;
    load(0, 4);
    load(1, 1);
    src_en[1] = 1'b1;
    drive();
    cycle();
    src_en[0] = 1'b1;
    drive();
    run_drain("t4_drain", 40);
    exp_q = '{1, 0, 0, 0, 0};
    check_seq("t4", 1'b0, 4);
    if (cyc_log.size() >= 2) chk("t4_switch_cycles", cyc_log[1] - cyc_log[0], 3);

    // strict alternation, N=3 MAX_BURST=1
    sel = 1'b1;
    reset_dut();
    nsrc = 3;
    for (int kk = 0; kk < 3; kk++) begin
      load(kk, 2);
      src_en[kk] = 1'b1;
    end
    drive();
    run_drain("t5_drain", 60);
    build_exp(1);
    check_seq("t5", 1'b1, 1);

    // random traffic with random downstream stalls on both configurations
    for (int s = 0; s < 2; s++) begin
      sel = (s == 1);
      reset_dut();
      nsrc = (s == 1) ? 3 : 2;
      sum = 0;
      for (int kk = 0; kk < nsrc; kk++) begin
        load(kk, int'($urandom_range(30, 5)));
        src_en[kk] = 1'b1;
        sum += src_len[kk];
      end
      gap_pct = 30;
      rnd_ready = 1'b1;
      drive();
      run_drain("t6_drain", 3000);
      chk("t6_count", src_log.size(), sum);
    end

    // reset asserted mid-burst of source 1
    sel = 1'b0;
    reset_dut();
    nsrc = 2;
    load(0, 1);
    load(1, 6);
    src_en[0] = 1'b1;
    src_en[1] = 1'b1;
    drive();
    n = 0;
    while (!(ob_valid && ob_src == 2'd1) && n < 20) begin
      cycle();
      n++;
    end
    chk("t7_reach_burst", {ob_valid, ob_src}, {1'b1, 2'd1});
    cycle();
    rst = 1'b0;
    #1;
    chk("t7_async_clear", {ob_valid, ob_src, ob_addr, ob_data, ob_ready}, 0);
    reset_model();
    @(posedge clk);
    #1;
    rst = 1'b1;
    load(0, 2);
    load(1, 2);
    src_en[0] = 1'b1;
    src_en[1] = 1'b1;
    drive();
    run_drain("t7_drain", 40);
    build_exp(4);
    check_seq("t7", 1'b0, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
